// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared types and helpers for the sequential magnitude comparator.
//            - cmp_state_t : controller states (IDLE, RUN, DONE)
//            - cmp_res_t   : one-bit-per-relation compare result {lt, eq, gt}
//            - sign_bias() : inverts the operand MSB so that a two's-complement
//                            compare can be performed by an unsigned datapath
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Widest operand supported by sign_bias(); callers zero-extend into it.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  // Flip bit (w-1) of v. Adding 2^(w-1) modulo 2^w maps the signed range
  // onto the unsigned range while preserving order.
  function automatic logic [MAX_W-1:0] sign_bias(input logic [MAX_W-1:0] v,
                                                 input int unsigned      w);
    sign_bias = v ^ (MAX_W'(1) << (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_comparator.sv
`default_nettype none
// ============================================================================
// Module   : chunk_comparator
// Purpose  : Combinational unsigned compare of one CHUNK-bit slice.
// Ports    : a, b [CHUNK-1:0] - operand slices
//            res  (cmp_res_t)  - exactly one of lt/eq/gt is set
// Revision : 1.0 - initial release
// ============================================================================
module chunk_comparator
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output cmp_res_t         res
);

  assign res.lt = (a <  b);
  assign res.eq = (a == b);
  assign res.gt = (a >  b);

endmodule
`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : seq_magnitude_comparator
// Purpose  : Multi-cycle WIDTH-bit magnitude comparator. Compares CHUNK bits
//            per cycle, MS chunk first, stopping at the first differing chunk.
//            Signed mode is handled by sign-biasing both operands on accept.
//            When operands are equal the latched cascade l/e/g is passed out.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready    - operand handshake (a, b, signed_mode, l/e/g)
//            out_valid/out_ready  - result handshake (L, E, G, cycles)
//            cycles               - RUN cycles spent on the current result
// Revision : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               signed_mode,
  input  logic                               l,
  input  logic                               e,
  input  logic                               g,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               L,
  output logic                               E,
  output logic                               G,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]   cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (NCHUNK < 1) || (WIDTH > MAX_W)) begin : g_param_check
      $error("seq_magnitude_comparator: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  cmp_state_t         r_state;
  cmp_state_t         w_state_n;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  cmp_res_t           r_casc;
  cmp_res_t           r_res;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cycles;
  cmp_res_t           w_chunk_res;

  chunk_comparator #(
    .CHUNK (CHUNK)
  ) u_chunk_comparator (
    .a   (r_a[int'(r_idx)*CHUNK +: CHUNK]),
    .b   (r_b[int'(r_idx)*CHUNK +: CHUNK]),
    .res (w_chunk_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_n = RUN;
      end
      RUN: begin
        if (w_chunk_res.lt || w_chunk_res.gt || (r_idx == '0)) w_state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, chunk walk, result and cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_casc   <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= signed_mode ? WIDTH'(sign_bias(MAX_W'(a), WIDTH)) : a;
            r_b      <= signed_mode ? WIDTH'(sign_bias(MAX_W'(b), WIDTH)) : b;
            r_casc   <= '{lt: l, eq: e, gt: g};
            r_res    <= '0;
            r_idx    <= IW'(NCHUNK - 1);
            r_cycles <= '0;
          end
        end
        RUN: begin
          r_cycles <= r_cycles + 1'b1;
          if (w_chunk_res.gt) begin
            r_res <= '{lt: 1'b0, eq: 1'b0, gt: 1'b1};
          end else if (w_chunk_res.lt) begin
            r_res <= '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
          end else if (r_idx == '0) begin
            // Whole operands equal: cascade passes through untouched.
            r_res <= r_casc;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_res <= '0;
        end
        default: r_res <= '0;
      endcase
    end
  end

  assign L      = r_res.lt;
  assign E      = r_res.eq;
  assign G      = r_res.gt;
  assign cycles = r_cycles;

endmodule
`default_nettype wire

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle, parametrised magnitude comparator that compares two WIDTH-bit operands CHUNK bits per cycle, most-significant chunk first, and terminates early at the first differing chunk.
- Supports unsigned and two's-complement signed compare.
- Keeps the lower-order cascade inputs (l/e/g), which decide the result when the operands are equal.
- Uses valid/ready handshakes on both input and output, so it sits between a producer and a consumer in compare/sort datapaths where a full-width single-cycle compare is too slow.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand/command valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
l  input  1  cascade less-than from lower-order stage
e  input  1  cascade equal from lower-order stage
g  input  1  cascade greater-than from lower-order stage
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
L  output  1  A < B
E  output  1  A == B
G  output  1  A > B
cycles  output  $clog2(NCHUNK+1)  number of RUN cycles used for this result

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; out_valid=0; L=E=G=0; cycles=0; in_ready=1 from the next cycle.
  - Reset in any state, including mid-RUN or DONE, aborts the operation with no result emitted.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready the block latches a, b, l, e and g.
  - If signed_mode=1, bit WIDTH-1 of both latched operands is inverted (sign-bias), so the datapath always compares unsigned.
  - Chunk index idx=NCHUNK-1, count=0, then go to RUN.
- RUN (in_ready=0):
  - Each cycle, compare chunk a[idx*CHUNK +: CHUNK] against the same slice of b as unsigned; count increments.
  - a-chunk > b-chunk: result G=1, go to DONE.
  - a-chunk < b-chunk: result L=1, go to DONE.
  - Chunks equal and idx==0: result is L=l, E=e, G=g exactly as latched (no validation or one-hot forcing); go to DONE.
  - Chunks equal and idx>0: idx decrements, stay in RUN.
- DONE:
  - out_valid=1; L/E/G and cycles hold stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid=0, L=E=G=0, go to IDLE.
  - in_ready=0 in DONE; there is no result/operand overlap.
- Latency, counted from the accept edge to the first cycle with out_valid=1, is k+1 cycles. k is the number of RUN cycles: 1 + (NCHUNK-1 - index of the first differing chunk), or NCHUNK if all chunks are equal.
- Throughput is one compare per k+2 cycles minimum, because of the 1-cycle IDLE between operations.
- Input signals are sampled only on the accept edge; changes while busy are ignored.
- Only one of L/E/G is produced by the datapath when chunks differ. Cascade values pass through unchanged when the operands are equal.
- Elaboration-time assertions: WIDTH%CHUNK==0, CHUNK>=1, NCHUNK>=1.
  - When NCHUNK==1, the RUN state resolves in one cycle.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum cmp_state_t {IDLE, RUN, DONE};
  - packed struct cmp_res_t {lt, eq, gt};
  - function sign_bias(), which inverts the MSB.
- One combinational sub-module, chunk_comparator, is parameterised by CHUNK.
  - Inputs: a, b. Output: cmp_res_t for the unsigned chunk compare.
  - The FSM, counters and handshake stay in the top module.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x1234, b=0x1234, l=0, e=1, g=0, unsigned, out_ready=1 -> E=1 (L=G=0), cycles=4, out_valid on the 5th cycle after accept.
- a=0x8000, b=0x7FFF, signed_mode=0 -> G=1, cycles=1. Same operands with signed_mode=1 -> L=1, cycles=1.
- a=0x1235, b=0x1234, any cascade -> G=1, cycles=4. Then a=0xFFFE, b=0xFFFF signed -> L=1, cycles=4.
- Equal operands a=b=0x00AA with cascade l=1, e=0, g=0 -> L=1, E=0, G=0.
  - Illegal cascade l=1, g=1 -> L=1, G=1 passed through unchanged.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> L/E/G/cycles stable and in_ready=0; out_ready=1 -> out_valid drops the next cycle and in_ready=1.
- Assert rst during the 2nd RUN cycle -> the next cycle has out_valid=0, L=E=G=0, in_ready=1, and no result is ever emitted for that operation. A new compare afterwards behaves normally.
